// File: rtl/tile_index_gen.sv
// Pixel-position walker that keeps pos, pos/9 and pos%9 in step, with a
// multiply-back load path (pos = 9*q + r) to jump to an arbitrary tile.
module tile_index_gen #(
  parameter int unsigned POS_W   = 13,
  parameter int unsigned Q_W     = 10,
  parameter int unsigned MAX_POS = 1439
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sol,
  input  logic             pix_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [Q_W-1:0]   load_q,
  input  logic [3:0]       load_r,
  output logic [POS_W-1:0] pos,
  output logic [Q_W-1:0]   quo,
  output logic [3:0]       rem,
  output logic             quo_lsb,
  output logic             eol,
  output logic             load_err
);

  typedef enum logic [1:0] {StRun, StMul, StCheck} state_e;

  localparam logic [POS_W-1:0] PosMax  = POS_W'(MAX_POS);
  localparam logic [POS_W:0]   ProdMax = (POS_W + 1)'(MAX_POS);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [3:0]       rem_q, rem_d;
  logic             eol_q, eol_d;
  logic             err_q, err_d;
  logic [Q_W-1:0]   ld_q_q, ld_q_d;
  logic [3:0]       ld_r_q, ld_r_d;
  logic [POS_W:0]   prod_q, prod_d;
  logic             accept;
  logic [POS_W:0]   q_ext;

  assign load_ready = (state_q == StRun) & ~sol;
  assign accept     = load_valid & load_ready;
  assign q_ext      = (POS_W + 1)'(ld_q_q);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    eol_d   = 1'b0;
    err_d   = 1'b0;
    ld_q_d  = ld_q_q;
    ld_r_d  = ld_r_q;
    prod_d  = prod_q;

    if (sol) begin
      // Start of line wins over everything and silently drops a pending load.
      state_d = StRun;
      pos_d   = '0;
      quo_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pix_en) begin
            if (pos_q == PosMax) begin
              pos_d = '0;
              quo_d = '0;
              rem_d = '0;
              eol_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
              if (rem_q == 4'd8) begin
                rem_d = '0;
                quo_d = quo_q + Q_W'(1);
              end else begin
                rem_d = rem_q + 4'd1;
              end
            end
          end
          if (accept) begin
            ld_q_d  = load_q;
            ld_r_d  = load_r;
            state_d = StMul;
          end
        end
        StMul: begin
          prod_d  = (q_ext << 3) + q_ext + (POS_W + 1)'(ld_r_q);
          state_d = StCheck;
        end
        StCheck: begin
          if ((ld_r_q > 4'd8) || (prod_q > ProdMax)) begin
            err_d = 1'b1;
          end else begin
            pos_d = prod_q[POS_W-1:0];
            quo_d = ld_q_q;
            rem_d = ld_r_q;
          end
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      pos_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q_q  <= '0;
      ld_r_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
      ld_q_q  <= ld_q_d;
      ld_r_q  <= ld_r_d;
      prod_q  <= prod_d;
    end
  end

  assign pos      = pos_q;
  assign quo      = quo_q;
  assign rem      = rem_q;
  assign quo_lsb  = quo_q[0];
  assign eol      = eol_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_tile_index_gen.sv
// Directed + random bench for tile_index_gen; a position-based reference
// model pushes expected outputs per cycle, compared after each clock edge.
module tb_tile_index_gen;

  localparam int MaxPos = 1439;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sol = 1'b0;
  logic        pix_en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [9:0]  load_q = '0;
  logic [3:0]  load_r = '0;
  logic [12:0] pos;
  logic [9:0]  quo;
  logic [3:0]  rem;
  logic        quo_lsb;
  logic        eol;
  logic        load_err;

  tile_index_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sol        (sol),
    .pix_en     (pix_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_q     (load_q),
    .load_r     (load_r),
    .pos        (pos),
    .quo        (quo),
    .rem        (rem),
    .quo_lsb    (quo_lsb),
    .eol        (eol),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int quo;
    int rem;
    int eol;
    int err;
    int ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  // Reference model: position plus a tiny load-phase counter (0 run, 1 mul, 2 check).
  int m_pos = 0;
  int m_st  = 0;
  int m_q   = 0;
  int m_r   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("pos", 32'(pos), e.pos);
    chk("quo", 32'(quo), e.quo);
    chk("rem", 32'(rem), e.rem);
    chk("quo_lsb", 32'(quo_lsb), e.quo & 1);
    chk("eol", 32'(eol), e.eol);
    chk("load_err", 32'(load_err), e.err);
    chk("load_ready", 32'(load_ready), e.ready);
    chk("invariant", 32'(pos), 9 * 32'(quo) + 32'(rem));
    chk("rem_le8", 32'(rem <= 4'd8), 32'd1);
  endtask

  task automatic step(input logic p, input logic s, input logic lv,
                      input logic [9:0] lq, input logic [3:0] lr);
    exp_t e;
    bit   acc;
    @(negedge clk);
    pix_en = p;
    sol = s;
    load_valid = lv;
    load_q = lq;
    load_r = lr;
    acc = lv && (m_st == 0) && !s;
    e.eol = 0;
    e.err = 0;
    if (s) begin
      m_pos = 0;
      m_st  = 0;
    end else begin
      case (m_st)
        0: begin
          if (p) begin
            if (m_pos == MaxPos) begin
              m_pos = 0;
              e.eol = 1;
            end else begin
              m_pos++;
            end
          end
          if (acc) begin
            m_q  = int'(lq);
            m_r  = int'(lr);
            m_st = 1;
          end
        end
        1: m_st = 2;
        default: begin
          if (m_r > 8 || m_q * 9 + m_r > MaxPos) e.err = 1;
          else m_pos = m_q * 9 + m_r;
          m_st = 0;
        end
      endcase
    end
    e.pos = m_pos;
    e.quo = m_pos / 9;
    e.rem = m_pos % 9;
    e.ready = (m_st == 0 && !s) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Asserts reset in the middle of the cycle that follows the last step.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    pix_en = 1'b0;
    sol = 1'b0;
    load_valid = 1'b0;
    #1;
    chk({tag, "_pos"}, 32'(pos), 32'd0);
    chk({tag, "_quo"}, 32'(quo), 32'd0);
    chk({tag, "_rem"}, 32'(rem), 32'd0);
    chk({tag, "_quo_lsb"}, 32'(quo_lsb), 32'd0);
    chk({tag, "_eol"}, 32'(eol), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    m_pos = 0;
    m_st = 0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_eol", 32'(eol), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: twenty pixels
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    chk("t1_pos20", 32'(pos), 32'd20);

    // 2: run to the end of line and wrap
    for (int i = 20; i < MaxPos; i++) step(1, 0, 0, 0, 0);
    chk("t2_pos_max", 32'(pos), 32'd1439);
    step(1, 0, 0, 0, 0);
    chk("t2_wrap_eol", 32'(eol), 32'd1);
    step(0, 0, 0, 0, 0);

    // 3: load 100/5 with pix_en held, then walk four pixels
    step(1, 0, 1, 10'd100, 4'd5);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t3_loaded", 32'(pos), 32'd905);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("t3_pos909", 32'(pos), 32'd909);

    // 4: rejected loads (bad offset, product past end of line)
    step(0, 0, 1, 10'd50, 4'd9);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 10'd160, 4'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // 5: sol aborts a load in flight
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 10'd10, 4'd3);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    // 6: async reset mid-count and mid-check
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    async_reset("rst_count");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 10'd20, 4'd4);
    step(0, 0, 0, 0, 0);
    async_reset("rst_check");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 7) == 0), 10'($urandom_range(0, 170)),
           4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tile_index_gen.md
# tile_index_gen

Sequential pixel-position walker for the BT656 active-line datapath. It counts the position along a line and tracks the exact quotient and remainder of that position divided by 9, with the quotient LSB available directly for tile and checker generation. This is the incremental counterpart of the combinational divide-by-9 path. It also runs the inverse mapping: a loaded tile index and offset are multiplied back (position = 9·q + r) to jump the walker to an arbitrary tile.

## Interface

Parameters:
- POS_W, default 13: position width.
- Q_W, default 10: quotient width.
- MAX_POS, default 1439: last valid position (720 pixels × 2 bytes − 1).

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sol, in, 1: start of line; synchronous clear of the walker.
- pix_en, in, 1: advance the position by one.
- load_valid, in, 1: load request.
- load_ready, out, 1: load may be accepted this cycle.
- load_q, in, Q_W: tile index to load.
- load_r, in, 4: offset within the tile to load.
- pos, out, POS_W: current position.
- quo, out, Q_W: pos / 9.
- rem, out, 4: pos mod 9.
- quo_lsb, out, 1: quo[0].
- eol, out, 1: one-cycle pulse on wrap past MAX_POS.
- load_err, out, 1: one-cycle pulse when a load is rejected.

## Operation

- Invariant, always: pos == 9·quo + rem, rem ≤ 8, pos ≤ MAX_POS.
- State machine has three states: RUN, MUL, CHECK.
- load_ready = (state == RUN) & !sol. This is combinational.
- A load is accepted in a cycle with load_valid & load_ready.
- RUN:
  - On pix_en, pos increments by 1.
  - rem increments, except at rem == 8, where rem goes to 0 and quo increments.
  - On pix_en at pos == MAX_POS, pos, quo and rem all go to 0, and eol is asserted for the next cycle.
  - On accept, load_q and load_r are captured and the state moves to MUL. A pix_en in the accept cycle is still applied.
- MUL:
  - prod = (q << 3) + q + r, computed at POS_W+1 bits with no overflow.
  - prod is registered and the state moves to CHECK.
  - pix_en is ignored.
- CHECK:
  - If r > 8 or prod > MAX_POS, load_err pulses and pos, quo and rem are unchanged.
  - Otherwise pos = prod, quo = q and rem = r.
  - The state returns to RUN. pix_en is ignored.
- sol has the highest priority in any state:
  - pos, quo and rem go to 0 and the state goes to RUN.
  - Any pending load is aborted without asserting load_err.
  - eol is not asserted.
- quo_lsb, eol and load_err are registered outputs, not decoded combinationally from inputs.

## Timing

- Reset:
  - pos, quo, rem, quo_lsb, eol and load_err are 0.
  - State is RUN, so load_ready is 1 while sol is low.
  - Reset takes effect immediately, mid-count or mid-load, and discards any pending load.
- Counting: outputs reflect a pix_en sampled at edge N in the cycle after edge N. The step is 1 position per cycle.
- Load latency (accept in cycle 0):
  - Cycle 1: state MUL.
  - Cycle 2: state CHECK.
  - Cycle 3: pos, quo and rem show the loaded values, or load_err is high for this one cycle.
  - load_ready is low in cycles 1–2 and high again in cycle 3.
- Wrap: eol is high only in the cycle in which the outputs read 0 after the wrap.
- Simultaneous events:
  - sol + pix_en: the walker clears and pix_en is dropped.
  - sol + load_valid: not accepted.
  - pix_en + accept: the count advances, then the load result overwrites it at cycle 3.

## Test plan

1. Release reset, then hold pix_en for 20 cycles → pos = 20, quo = 2, rem = 2, quo_lsb = 0, eol never high.
2. Count to pos = 1439 (quo = 159, rem = 8), then one more pix_en → pos, quo and rem = 0, eol high for exactly one cycle, invariant holds throughout.
3. Load q = 100, r = 5 with pix_en held high → load_ready low for 2 cycles, pos = 905 in cycle 3. Then 4 × pix_en → pos = 909, quo = 101, rem = 0, quo_lsb = 1.
4. Load q = 50, r = 9, then load q = 160, r = 0 (prod = 1440) → load_err pulses once per load and pos, quo and rem are unchanged each time.
5. Accept a load of q = 10, r = 3 at pos = 40, then assert sol during MUL → counters go to 0, no load_err, no load update in later cycles, load_ready high the cycle after sol drops.
6. Assert reset_n low asynchronously mid-count and mid-CHECK → all outputs go to 0 before the next edge. Follow with 2000 cycles of random pix_en, sol and load traffic, checking the invariant and rem ≤ 8 every cycle.
